// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives the data SRAM on acceptance and returns one aligned,
// extended response per request. Define MEM_ADDR_EXC_EN to trap misaligned halfword/word accesses.
module mem_access_unit #(
    parameter logic [4:0] EXC_ADEL = 5'h04,
    parameter logic [4:0] EXC_ADES = 5'h05
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_is_load,
    output logic        resp_exc,
    output logic [4:0]  resp_exc_code,
    output logic [31:0] resp_badvaddr
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;
    logic        exc_q, exc_d;
    logic [31:0] hold_q, hold_d;

    logic        accept, is_load, is_store, mis;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] fmt_rdata;

    assign resp_valid = (state_q != IDLE);
    assign req_ready  = !resp_valid || resp_ready;
    // Gated by resetn so the SRAM port stays quiet while reset is held.
    assign accept     = resetn && req_valid && req_ready && !flush;
    assign is_load    = (req_op == OP_LB) || (req_op == OP_LBU) || (req_op == OP_LH) ||
                        (req_op == OP_LHU) || (req_op == OP_LW);
    assign is_store   = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);

`ifdef MEM_ADDR_EXC_EN
    assign mis = (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]) ||
                 (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        if (accept && (is_load || is_store) && !mis) begin
            data_sram_en   = 1'b1;
            data_sram_addr = {req_addr[31:2], 2'b00};
            case (req_op)
                OP_SB: begin
                    data_sram_wen   = 4'b0001 << req_addr[1:0];
                    data_sram_wdata = {4{req_wdata[7:0]}};
                end
                OP_SH: begin
                    data_sram_wen   = req_addr[1] ? 4'b1100 : 4'b0011;
                    data_sram_wdata = {2{req_wdata[15:0]}};
                end
                OP_SW: begin
                    data_sram_wen   = 4'hF;
                    data_sram_wdata = req_wdata;
                end
                default: ;
            endcase
        end
    end

    // Only bit 1 of the offset picks the halfword, so misaligned halves fall back to the aligned one.
    always_comb begin
        rd_byte   = data_sram_rdata[{off_q, 3'b000} +: 8];
        rd_half   = off_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        fmt_rdata = 32'h0;
        if (!exc_q) begin
            case (op_q)
                OP_LB:   fmt_rdata = {{24{rd_byte[7]}}, rd_byte};
                OP_LBU:  fmt_rdata = {24'h0, rd_byte};
                OP_LH:   fmt_rdata = {{16{rd_half[15]}}, rd_half};
                OP_LHU:  fmt_rdata = {16'h0, rd_half};
                OP_LW:   fmt_rdata = data_sram_rdata;
                default: fmt_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        is_load_d = is_load_q;
        exc_d     = exc_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = accept ? RESP : IDLE;
                end else begin
                    state_d = HOLD;
                    hold_d  = fmt_rdata;
                end
            end
            HOLD:    if (resp_ready) state_d = accept ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d      = req_op;
            off_d     = req_addr[1:0];
            is_load_d = is_load;
            exc_d     = mis;
        end
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            op_q      <= 8'h0;
            off_q     <= 2'b00;
            is_load_q <= 1'b0;
            exc_q     <= 1'b0;
            hold_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            off_q     <= off_d;
            is_load_q <= is_load_d;
            exc_q     <= exc_d;
            hold_q    <= hold_d;
        end
    end

    assign resp_rdata   = (state_q == RESP) ? fmt_rdata : (state_q == HOLD) ? hold_q : 32'h0;
    assign resp_is_load = resp_valid && is_load_q;

`ifdef MEM_ADDR_EXC_EN
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    always_comb begin
        exc_code_d = exc_code_q;
        badvaddr_d = badvaddr_q;
        if (accept) begin
            exc_code_d = mis ? (is_load ? EXC_ADEL : EXC_ADES) : 5'h0;
            badvaddr_d = mis ? req_addr : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_code_q <= 5'h0;
            badvaddr_q <= 32'h0;
        end else begin
            exc_code_q <= exc_code_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign resp_exc      = resp_valid && exc_q;
    assign resp_exc_code = resp_valid ? exc_code_q : 5'h0;
    assign resp_badvaddr = resp_valid ? badvaddr_q : 32'h0;
`else
    assign resp_exc      = 1'b0;
    assign resp_exc_code = 5'h0;
    assign resp_badvaddr = 32'h0;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine of the single-issue MIPS core.
- Consumes the byte address computed by the EX-stage ALU, together with the memory opcode (EXE_LB_OP … EXE_SW_OP from defines2.vh) and the store data.
- Drives the synchronous data-SRAM port, then aligns and extends the load data one cycle later.
- Returns one response per accepted request through a valid/ready handshake toward WB.

Parameters:
- EXC_ADEL, 5'h04, exception code reported for a misaligned load.
- EXC_ADES, 5'h05, exception code reported for a misaligned store.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- req_valid  in  1  EX→MEM request valid.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  8  alucontrol opcode.
- req_addr  in  32  ALU result, byte address.
- req_wdata  in  32  rt value for stores.
- data_sram_en  out  1  SRAM access enable.
- data_sram_wen  out  4  byte write enables; 0 means read.
- data_sram_addr  out  32  word address {req_addr[31:2],2'b00}.
- data_sram_wdata  out  32  replicated store data.
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the access.
- resp_valid  out  1  response valid.
- resp_ready  in  1  WB accepts the response.
- resp_rdata  out  32  aligned, extended load result; 0 for stores.
- resp_is_load  out  1  response belongs to a load.
- resp_exc  out  1  address error.
- resp_exc_code  out  5  EXC_ADEL or EXC_ADES.
- resp_badvaddr  out  32  faulting byte address.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; resp_valid=0; resp_rdata=0; resp_is_load=0; resp_exc=0; resp_exc_code=0; resp_badvaddr=0; hold register=0.
  - SRAM outputs en=0, wen=0, addr=0, wdata=0.
  - Reset mid-operation drops any pending response with no replay.
- Acceptance:
  - req_ready = !resp_valid || resp_ready.
  - A request is accepted when req_valid && req_ready && !flush.
- SRAM drive on acceptance, same cycle, combinational:
  - data_sram_en=1 only if the opcode is a load or store and is not faulting.
  - Loads: wen=0.
  - SB: wen = 4'b0001 << addr[1:0]; wdata = {4{req_wdata[7:0]}}.
  - SH: wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{req_wdata[15:0]}}.
  - SW: wen=4'hF; wdata=req_wdata.
  - Non-memory opcode: en=0, and the response still carries resp_rdata=0 and resp_is_load=0.
- Latency:
  - Response is valid the cycle after acceptance.
  - Load data is formatted from data_sram_rdata using the registered op and addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - LB byte k = rdata[8k+7:8k]; LH half = addr[1] ? rdata[31:16] : rdata[15:0].
- State machine:
  - IDLE (resp_valid=0) → RESP on acceptance.
  - RESP (resp_valid=1, rdata from SRAM):
    - resp_ready=1 with a new acceptance → stay in RESP.
    - resp_ready=1 with no acceptance → IDLE.
    - resp_ready=0 → HOLD, latching the formatted rdata into the hold register.
  - HOLD (resp_valid=1, rdata from the hold register):
    - resp_ready=1 → RESP if a new request is accepted, else IDLE.
    - Otherwise stay in HOLD with outputs stable.
- Stores respond with resp_rdata=0.
- Flush:
  - Any state → IDLE next cycle; resp_valid falls.
  - A request presented in the flush cycle is discarded with en=0.
  - A flush in the acceptance cycle blocks the SRAM write.
- Each accepted request produces exactly one response; requests are never reordered.

Optional Feature:
- Macro: MEM_ADDR_EXC_EN.
- Misalignment is defined as:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- When defined:
  - A misaligned request is accepted normally, but en=0 and wen=0, so there is no SRAM access.
  - Its response has resp_exc=1, resp_exc_code = EXC_ADEL (load) or EXC_ADES (store), resp_badvaddr=req_addr, and resp_rdata=0.
- When undefined:
  - resp_exc, resp_exc_code and resp_badvaddr are tied 0.
  - Offending low address bits are treated as 0: halfword uses addr[1], word uses offset 0.
  - The access proceeds.

Test Plan:
- LB at 0x00000003, SRAM word 0x80FF1234 → en=1, wen=0, sram addr 0x00000000; next cycle resp_rdata=0xFFFFFF80, resp_is_load=1.
- SH at 0x00000102, req_wdata=0xDEADBEEF → wen=4'b1100, sram wdata 0xBEEFBEEF, sram addr 0x00000100; resp_valid next cycle with resp_rdata=0.
- Back-to-back LW 0x10 then LHU 0x16 with resp_ready=1, SRAM words 0x11223344 then 0xAABBCCDD → responses on consecutive cycles: 0x11223344, then 0x0000AABB.
- LW returning 0xCAFEF00D with resp_ready=0 for 3 cycles while SRAM rdata changes → resp_rdata stays 0xCAFEF00D; req_ready=0 throughout; one response delivered when resp_ready rises.
- SW at 0x20 with flush=1 in the same cycle → en=0, wen=0; no response. A flush while in HOLD → resp_valid=0 next cycle.
- With MEM_ADDR_EXC_EN defined: LW at 0x00000006 → en=0; response resp_exc=1, code 0x04, badvaddr 0x00000006. SH at 0x00000001 → code 0x05.
